spi_reg_ctrl: RTL and testbench

Command/register controller that sits behind the SPI slave byte engine and sequences it. It parses each chip-select frame into a command byte followed by data bytes, and writes or reads a small register file with address auto-increment. For reads it loads the slave's transmit byte. Register 0 drives the board LEDs, replacing the direct "last received byte -> LED" path.

---
 rtl/spi_reg_ctrl.sv | 158 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: splits each chip-select frame into a command byte plus data bytes
// and reads/writes a small register file with address auto-increment.
// Latency: register write and tx_load follow the triggering rx_valid by 1 cycle.
// Backpressure: none; the byte engine paces everything via rx_valid, so clk >= 4x SCK.
// Ports: clk/rst (async, active high); ssel (active low, pre-synchronized);
//   rx_byte/rx_valid from the SPI slave; tx_byte/tx_load to the SPI slave;
//   led = register 0; busy = frame open; err = sticky illegal-command flag.
module spi_reg_ctrl #(
  parameter int          NUM_REGS = 8,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ssel,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] led,
  output logic       busy,
  output logic       err
);

  localparam int             AW         = $clog2(NUM_REGS);
  localparam logic [AW-1:0]  TOP        = AW'(NUM_REGS - 1);
  // Command bits between CLR and the address field that must be zero.
  localparam int             ILL_MASK_I = 'h3F & ~((1 << AW) - 1);
  localparam logic [7:0]     ILL_MASK   = ILL_MASK_I[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            ssel_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   addr_inc;
  logic            clr_q, clr_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_load_q, tx_load_d;
  logic            err_q, err_d;
  logic            wr_en;
  logic [7:0]      regs [NUM_REGS];
  logic [7:0]      rd_cmd;
  logic [7:0]      rd_next;
  logic [AW-1:0]   cmd_addr;

  assign cmd_addr = rx_byte[AW-1:0];
  assign addr_inc = addr_q + AW'(1);
  // The top register is never stored; it always reads back the ID constant.
  assign rd_cmd   = (cmd_addr == TOP) ? ID_VALUE : regs[cmd_addr];
  assign rd_next  = (addr_inc == TOP) ? ID_VALUE : regs[addr_inc];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    clr_d     = clr_q;
    tx_byte_d = 8'h00;
    tx_load_d = 1'b0;
    err_d     = err_q;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Falling edge on the registered copy; the slave gets 0x00 for the command byte.
        if (ssel_q && !ssel) begin
          state_d   = S_CMD;
          tx_load_d = 1'b1;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          if ((rx_byte & ILL_MASK) != 8'h00) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            addr_d = cmd_addr;
            clr_d  = rx_byte[6];
            if (rx_byte[7]) begin
              state_d   = S_READ;
              tx_byte_d = rd_cmd;
              tx_load_d = 1'b1;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (rx_valid) begin
          wr_en  = 1'b1;
          addr_d = addr_inc;
          if (clr_q && (addr_q == '0)) begin
            err_d = 1'b0;
          end
        end
      end
      S_READ: begin
        tx_byte_d = tx_byte_q;
        if (rx_valid) begin
          addr_d    = addr_inc;
          tx_byte_d = rd_next;
          tx_load_d = 1'b1;
        end
      end
      S_ERR: begin
      end
      default: state_d = S_IDLE;
    endcase
    // Chip select released: a byte arriving this same cycle was already
    // handled above (writes commit), but nothing more goes to the slave.
    if ((state_q != S_IDLE) && ssel) begin
      state_d   = S_IDLE;
      tx_byte_d = 8'h00;
      tx_load_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ssel_q    <= 1'b1;
      addr_q    <= '0;
      clr_q     <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ssel_q    <= ssel;
      addr_q    <= addr_d;
      clr_q     <= clr_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (wr_en && (addr_q != TOP)) begin
      regs[addr_q] <= rx_byte;
    end
  end

  assign tx_byte = tx_byte_q;
  assign tx_load = tx_load_q;
  assign led     = regs[0];
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ssel;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [7:0] led;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.NUM_REGS(8), .ID_VALUE(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .ssel     (ssel),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .tx_byte  (tx_byte),
    .tx_load  (tx_load),
    .led      (led),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic       ssel;
    logic       rv;
    logic [7:0] rb;
    logic       ld;
    logic [7:0] tx;
    logic [7:0] led;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic s, logic v, logic [7:0] b, logic ld,
                              logic [7:0] tx, logic [7:0] l, logic bz, logic e);
    vec_t r;
    r.ssel = s; r.rv = v; r.rb = b; r.ld = ld;
    r.tx = tx; r.led = l; r.busy = bz; r.err = e;
    vecs.push_back(r);
  endfunction

  task automatic check_out(input string name, input logic ld, input logic [7:0] tx,
                           input logic [7:0] l, input logic bz, input logic e);
    logic [18:0] act;
    logic [18:0] exp;
    act = {tx_load, tx_byte, led, busy, err};
    exp = {ld, tx, l, bz, e};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got tx_load=%0b tx_byte=%02h led=%02h busy=%0b err=%0b, want tx_load=%0b tx_byte=%02h led=%02h busy=%0b err=%0b",
               name, tx_load, tx_byte, led, busy, err, ld, tx, l, bz, e);
    end
  endtask

  // One clock: drive inputs, take the edge, check outputs 1 ns later.
  task automatic step(input string name, input logic s, input logic v, input logic [7:0] b,
                      input logic ld, input logic [7:0] tx, input logic [7:0] l,
                      input logic bz, input logic e);
    ssel     = s;
    rx_valid = v;
    rx_byte  = b;
    @(posedge clk);
    #1;
    check_out(name, ld, tx, l, bz, e);
  endtask

  initial begin
    rst      = 1'b1;
    ssel     = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    #12;
    check_out("reset_values", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //   ssel rv  rb     ld tx     led    busy err
    add(1, 0, 8'h00,  0, 8'h00, 8'h00, 0, 0);
    // Write burst {01,11,22}
    add(0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h01,  0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h11,  0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h22,  0, 8'h00, 8'h00, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h00, 0, 0);
    // LED write with wrap {06,AA,BB,3C}
    add(0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h06,  0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'hAA,  0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'hBB,  0, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h3C,  0, 8'h00, 8'h3C, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h3C, 0, 0);
    // Preload reg1=5A, reg2=C3
    add(0, 0, 8'h00,  1, 8'h00, 8'h3C, 1, 0);
    add(0, 1, 8'h01,  0, 8'h00, 8'h3C, 1, 0);
    add(0, 1, 8'h5A,  0, 8'h00, 8'h3C, 1, 0);
    add(0, 1, 8'hC3,  0, 8'h00, 8'h3C, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h3C, 0, 0);
    // Read burst {81,d,d} with idle gaps; reg3 is still 0
    add(0, 0, 8'h00,  1, 8'h00, 8'h3C, 1, 0);
    add(0, 1, 8'h81,  1, 8'h5A, 8'h3C, 1, 0);
    add(0, 0, 8'h00,  0, 8'h5A, 8'h3C, 1, 0);
    add(0, 1, 8'hFF,  1, 8'hC3, 8'h3C, 1, 0);
    add(0, 0, 8'h00,  0, 8'hC3, 8'h3C, 1, 0);
    add(0, 1, 8'hFF,  1, 8'h00, 8'h3C, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h3C, 0, 0);
    // Read {86,d,d}: reg6, ID register, wrap to reg0
    add(0, 0, 8'h00,  1, 8'h00, 8'h3C, 1, 0);
    add(0, 1, 8'h86,  1, 8'hAA, 8'h3C, 1, 0);
    add(0, 1, 8'hFF,  1, 8'hA5, 8'h3C, 1, 0);
    add(0, 1, 8'hFF,  1, 8'h3C, 8'h3C, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h3C, 0, 0);
    // Illegal command {28,77}: err set, reg0 untouched
    add(0, 0, 8'h00,  1, 8'h00, 8'h3C, 1, 0);
    add(0, 1, 8'h28,  0, 8'h00, 8'h3C, 1, 1);
    add(0, 1, 8'h77,  0, 8'h00, 8'h3C, 1, 1);
    add(1, 0, 8'h00,  0, 8'h00, 8'h3C, 0, 1);
    // Clear via {40,00}
    add(0, 0, 8'h00,  1, 8'h00, 8'h3C, 1, 1);
    add(0, 1, 8'h40,  0, 8'h00, 8'h3C, 1, 1);
    add(0, 1, 8'h00,  0, 8'h00, 8'h00, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h00, 0, 0);
    // Last write byte coincides with ssel rising; then rx_valid while idle
    add(0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h05,  0, 8'h00, 8'h00, 1, 0);
    add(1, 1, 8'h66,  0, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h99,  0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h85,  1, 8'h66, 8'h00, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h00, 0, 0);
    // Abort after command byte, stray byte with ssel high, read back reg4
    add(0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h04,  0, 8'h00, 8'h00, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h00, 0, 0);
    add(1, 1, 8'h55,  0, 8'h00, 8'h00, 0, 0);
    add(0, 0, 8'h00,  1, 8'h00, 8'h00, 1, 0);
    add(0, 1, 8'h84,  1, 8'h00, 8'h00, 1, 0);
    add(1, 0, 8'h00,  0, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].ssel, vecs[i].rv, vecs[i].rb,
           vecs[i].ld, vecs[i].tx, vecs[i].led, vecs[i].busy, vecs[i].err);
    end

    // Reset pulsed in the middle of a write burst to reg0/reg1.
    step("mid_cmd",  0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 0);
    step("mid_c00",  0, 1, 8'h00, 0, 8'h00, 8'h00, 1, 0);
    step("mid_w12",  0, 1, 8'h12, 0, 8'h00, 8'h12, 1, 0);
    step("mid_w34",  0, 1, 8'h34, 0, 8'h00, 8'h12, 1, 0);
    rx_valid = 1'b0;
    ssel     = 1'b1;
    rst      = 1'b1;
    #2;
    check_out("mid_reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Fresh frame {03,09}, then read back reg3..reg5 (reg5 must be cleared).
    step("post_cmd", 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 0);
    step("post_c03", 0, 1, 8'h03, 0, 8'h00, 8'h00, 1, 0);
    step("post_w09", 0, 1, 8'h09, 0, 8'h00, 8'h00, 1, 0);
    step("post_end", 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step("rb_cmd",   0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 0);
    step("rb_reg3",  0, 1, 8'h83, 1, 8'h09, 8'h00, 1, 0);
    step("rb_reg4",  0, 1, 8'hFF, 1, 8'h00, 8'h00, 1, 0);
    step("rb_reg5",  0, 1, 8'hFF, 1, 8'h00, 8'h00, 1, 0);
    step("rb_end",   1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
